// File: rtl/bus_mem_if.sv
// CPU/loader/I-O bus bundle for bus_mem; master drives requests, slave is the memory.
interface bus_mem_if;
  logic [5:0] addr;
  logic       rw;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       ld_done;
  logic       cpu_hold;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       io_strobe;

  modport master (
    output addr, rw, data_in, ld_start, ld_valid, ld_data, ld_last, io_in,
    input  data_out, ld_ready, ld_done, cpu_hold, io_out, io_strobe
  );

  modport slave (
    input  addr, rw, data_in, ld_start, ld_valid, ld_data, ld_last, io_in,
    output data_out, ld_ready, ld_done, cpu_hold, io_out, io_strobe
  );
endinterface

// File: rtl/bus_mem.sv
// 64-byte CPU program/data memory with byte-serial loader that holds the CPU in reset.
// Define BUS_MEM_IO_EN to map an input port at IO_IN_ADDR and an output port at IO_OUT_ADDR.
module bus_mem #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [5:0]  IO_IN_ADDR  = 6'd62,
  parameter logic [5:0]  IO_OUT_ADDR = 6'd63
) (
  input  logic      clk,
  input  logic      reset,
  bus_mem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t     r_state, w_state_nxt;
  logic [5:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_data_out;
  logic [7:0] w_rd_data;
  logic       w_ld_we;
  logic       w_cpu_we;
  logic       w_ptr_last;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ld_we     = 1'b0;
    w_cpu_we    = 1'b0;
    w_ptr_last  = (r_ptr == 6'(DEPTH - 1));
    case (r_state)
      IDLE: begin
        if (bus.ld_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      LOAD: begin
        // pointer saturates at the top address; that accept also ends the load
        if (bus.ld_valid) begin
          w_ld_we = 1'b1;
          if (!w_ptr_last) w_ptr_nxt = r_ptr + 6'd1;
          if (bus.ld_last || w_ptr_last) w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_cpu_we = !bus.rw;
        if (bus.ld_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // contents survive reset; writes are only suppressed during it
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_ld_we)       r_mem[r_ptr]    <= bus.ld_data;
      else if (w_cpu_we) r_mem[bus.addr] <= bus.data_in;
    end
  end

`ifdef BUS_MEM_IO_EN
  logic       r_rw_q;
  logic [7:0] r_io_out;
  logic       r_io_strobe;
  logic       w_io_wr;

  assign w_io_wr   = w_cpu_we && (bus.addr == IO_OUT_ADDR);
  assign w_rd_data = (bus.addr == IO_IN_ADDR) ? bus.io_in : r_mem[bus.addr];

  // strobe only on the first cycle of the two-cycle store (rw falling edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rw_q      <= 1'b1;
      r_io_out    <= '0;
      r_io_strobe <= 1'b0;
    end else begin
      r_rw_q      <= bus.rw;
      r_io_strobe <= w_io_wr && r_rw_q;
      if (w_io_wr) r_io_out <= bus.data_in;
    end
  end

  assign bus.io_out    = r_io_out;
  assign bus.io_strobe = r_io_strobe;
`else
  logic w_unused;

  assign w_unused      = ^{bus.io_in, IO_IN_ADDR, IO_OUT_ADDR};
  assign w_rd_data     = r_mem[bus.addr];
  assign bus.io_out    = '0;
  assign bus.io_strobe = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_data_out <= '0;
    else       r_data_out <= w_rd_data;
  end

  assign bus.data_out = r_data_out;
  assign bus.ld_ready = (r_state == LOAD);
  assign bus.ld_done  = (r_state == RUN);
  assign bus.cpu_hold = (r_state != RUN);

endmodule
